uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 133 +++++++++++++
 tb/tb_uart_tx_sched.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Multi-requester UART transmitter: round-robin byte arbitration with optional
// per-line grant lock (held until a newline or an idle timeout), 8N1 framing.
module uart_tx_sched #(
  parameter int unsigned N_REQ           = 4,
  parameter int unsigned CLKS_PER_BIT    = 868,
  parameter int unsigned LOCK_ON_NEWLINE = 1,
  parameter int unsigned LOCK_TIMEOUT    = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [8*N_REQ-1:0]       req_data_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic                     tx_o,
  output logic [$clog2(N_REQ)-1:0] grant_o,
  output logic                     busy_o
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nx;
  logic [BW-1:0]   bit_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      tx_byte;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   lock_idx;
  logic            lock_vld;
  logic [TW-1:0]   idle_cnt;
  logic [PW-1:0]   sel;
  logic            found;
  logic            accept;
  logic            bit_done;
  logic [7:0]      sel_data;

  // Requester selection: locked requester only, else first valid from rr_ptr.
  always_comb begin : arb
    int unsigned c;
    c     = 0;
    found = 1'b0;
    sel   = rr_ptr;
    if (lock_vld) begin
      found = req_valid_i[lock_idx];
      sel   = lock_idx;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        c = 32'(rr_ptr) + i;
        if (c >= N_REQ) c = c - N_REQ;
        if (!found && req_valid_i[PW'(c)]) begin
          found = 1'b1;
          sel   = PW'(c);
        end
      end
    end
  end

  // rst_n gates ready so nothing is offered while reset is held.
  assign accept   = rst_n && (state == IDLE) && found;
  assign sel_data = req_data_i[{sel, 3'b000} +: 8];
  assign bit_done = (bit_cnt == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    req_ready_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++)
      req_ready_o[k] = accept && (sel == PW'(k));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_o     = 1'b1;
    busy_o   = 1'b1;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (accept) state_nx = START;
      end
      START: begin
        tx_o = 1'b0;
        if (bit_done) state_nx = DATA;
      end
      DATA: begin
        tx_o = tx_byte[bit_idx];
        if (bit_done && bit_idx == 3'd7) state_nx = STOP;
      end
      STOP: begin
        if (bit_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      bit_idx  <= '0;
      tx_byte  <= '0;
      grant_o  <= '0;
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
      idle_cnt <= '0;
    end else begin
      if (state == IDLE || bit_done) bit_cnt <= '0;
      else                           bit_cnt <= bit_cnt + BW'(1);

      // bit_idx naturally wraps 7->0 on the DATA->STOP transition.
      if (state == DATA && bit_done) bit_idx <= bit_idx + 3'd1;

      if (accept) begin
        tx_byte  <= sel_data;
        grant_o  <= sel;
        rr_ptr   <= (sel == PW'(N_REQ - 1)) ? '0 : sel + PW'(1);
        idle_cnt <= '0;
        if (LOCK_ON_NEWLINE != 0) begin
          lock_vld <= (sel_data != 8'h0A);
          lock_idx <= sel;
        end
      end else if (state == IDLE && lock_vld && !req_valid_i[lock_idx]) begin
        if (idle_cnt != TW'(LOCK_TIMEOUT)) idle_cnt <= idle_cnt + TW'(1);
        if (idle_cnt == TW'(LOCK_TIMEOUT - 1)) lock_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: expected (requester, byte) pairs are
// queued at stimulus time and retired on acceptance and on decoded frames.
module tb_uart_tx_sched;

  localparam int unsigned N   = 4;
  localparam int unsigned CPB = 4;
  localparam int unsigned TMO = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             tx;
  logic [1:0]       grant;
  logic             busy;

  uart_tx_sched #(
    .N_REQ(N), .CLKS_PER_BIT(CPB), .LOCK_ON_NEWLINE(1), .LOCK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .tx_o(tx), .grant_o(grant), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned req;
    logic [7:0]  data;
  } acc_t;

  acc_t        exp_acc[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  src_q[N][$];
  int unsigned acc_cyc[$];
  int unsigned n_checks  = 0;
  int unsigned n_pass    = 0;
  int unsigned cyc       = 0;
  int unsigned acc_count = 0;

  function automatic void send(int unsigned r, logic [7:0] d);
    acc_t e;
    e.req  = r;
    e.data = d;
    exp_acc.push_back(e);
    src_q[r].push_back(d);
  endfunction

  // Source driver, acceptance checker, grant checker and UART decoder.
  task automatic agent();
    logic [N-1:0] rdy;
    bit           mon_act = 1'b0;
    int unsigned  mon_cnt = 0;
    int unsigned  b;
    logic [7:0]   mon_byte = '0;
    logic [7:0]   want;
    bit           gpend = 1'b0;
    int unsigned  gexp = 0;
    int unsigned  k;
    acc_t         e;
    forever begin
      @(negedge clk);
      cyc++;
      rdy = req_ready;
      if (!rst_n) begin
        mon_act = 1'b0;
        gpend   = 1'b0;
        tx_q.delete();
        if (rdy != '0) begin
          n_checks++;
          $display("FAIL ready_in_reset got %b want 0000", rdy);
        end
      end else begin
        if (gpend) begin
          n_checks++;
          if (grant !== 2'(gexp)) $display("FAIL grant got %0d want %0d", grant, gexp);
          else n_pass++;
          gpend = 1'b0;
        end
        if (rdy != '0) begin
          k = N;
          for (int i = 0; i < N; i++) if (rdy[i] && k == N) k = i;
          n_checks++;
          if (exp_acc.size() == 0) begin
            $display("FAIL accept_unexpected got ready %b want none", rdy);
          end else begin
            e = exp_acc.pop_front();
            if ($countones(rdy) != 1 || k != e.req)
              $display("FAIL accept_req got ready %b want req %0d", rdy, e.req);
            else n_pass++;
            tx_q.push_back(e.data);
            gexp  = e.req;
            gpend = 1'b1;
          end
          acc_cyc.push_back(cyc);
          acc_count++;
        end
        if (!mon_act) begin
          if (tx === 1'b0) begin
            mon_act = 1'b1;
            mon_cnt = 0;
          end
        end else begin
          mon_cnt++;
          if (mon_cnt % CPB == CPB / 2) begin
            b = mon_cnt / CPB;
            if (b == 0) begin
              n_checks++;
              if (tx !== 1'b0) $display("FAIL start_bit got %b want 0", tx);
              else n_pass++;
            end else if (b <= 8) begin
              mon_byte[3'(b - 1)] = tx;
            end else begin
              mon_act = 1'b0;
              n_checks++;
              if (tx !== 1'b1) $display("FAIL stop_bit got %b want 1", tx);
              else if (tx_q.size() == 0) $display("FAIL frame_unexpected got %h want none", mon_byte);
              else begin
                want = tx_q.pop_front();
                if (mon_byte !== want) $display("FAIL frame_byte got %h want %h", mon_byte, want);
                else n_pass++;
              end
            end
          end
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rdy[i] && src_q[i].size() != 0) src_q[i].delete(0);
        req_valid[i] = (src_q[i].size() != 0);
        req_data[8*i +: 8] = req_valid[i] ? src_q[i][0] : 8'h00;
      end
    end
  endtask

  task automatic wait_acc(input int unsigned a0, input int unsigned budget);
    int unsigned n = 0;
    while (acc_count == a0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (acc_count == a0) $display("FAIL accept_timeout got none want accept within %0d", budget);
    else n_pass++;
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n = 0;
    while ((exp_acc.size() != 0 || tx_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (exp_acc.size() != 0 || tx_q.size() != 0 || busy)
      $display("FAIL drain_timeout got pending %0d/%0d want 0/0", exp_acc.size(), tx_q.size());
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int unsigned c0, a0;
    rst_n = 1'b0;
    send(0, 8'h5A);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (tx !== 1'b1) $display("FAIL rst_tx got %b want 1", tx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (req_ready !== '0) $display("FAIL rst_ready got %b want 0000", req_ready); else n_pass++;
    n_checks++; if (grant !== 2'd0) $display("FAIL rst_grant got %0d want 0", grant); else n_pass++;
    rst_n = 1'b1;
    c0 = cyc;
    a0 = acc_count;
    wait_acc(a0, 5);
    n_checks++;
    if (acc_cyc[$] != c0 + 1) $display("FAIL first_accept got cycle %0d want %0d", acc_cyc[$], c0 + 1);
    else n_pass++;
    wait_drain(80);
  endtask

  task automatic test_single();
    logic [7:0]  pat = 8'h55;
    logic        et, eb;
    int unsigned wave_err = 0;
    int unsigned busy_cnt = 0;
    int unsigned a0;
    do_reset();
    a0 = acc_count;
    send(0, pat);
    wait_acc(a0, 10);
    for (int unsigned i = 1; i <= 41; i++) begin
      @(negedge clk);
      #1;
      if (i <= 4)       et = 1'b0;
      else if (i <= 36) et = pat[3'((i - 5) / 4)];
      else              et = 1'b1;
      eb = (i <= 40);
      if (tx !== et || busy !== eb) wave_err++;
      if (busy === 1'b1) busy_cnt++;
    end
    n_checks++; if (wave_err != 0) $display("FAIL single_wave got %0d bad cycles want 0", wave_err); else n_pass++;
    n_checks++; if (busy_cnt != 40) $display("FAIL single_busy got %0d want 40", busy_cnt); else n_pass++;
    wait_drain(20);
  endtask

  task automatic test_simultaneous();
    int unsigned a0;
    do_reset();
    a0 = acc_count;
    send(0, 8'h0A);
    send(2, 8'h0A);
    wait_acc(a0, 10);
    wait_acc(a0 + 1, 60);
    n_checks++;
    if (acc_cyc[$] - acc_cyc[$-1] != 41)
      $display("FAIL simul_gap got %0d want 41", acc_cyc[$] - acc_cyc[$-1]);
    else n_pass++;
    wait_drain(80);
  endtask

  task automatic test_lock();
    do_reset();
    send(1, 8'h48);
    send(1, 8'h69);
    send(1, 8'h0A);
    send(3, 8'h41);
    wait_drain(400);
    n_checks++;
    if (acc_cyc[$] - acc_cyc[$-1] != 41)
      $display("FAIL lock_release_gap got %0d want 41", acc_cyc[$] - acc_cyc[$-1]);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int unsigned a0;
    do_reset();
    a0 = acc_count;
    send(1, 8'h41);
    wait_acc(a0, 10);
    send(2, 8'h33);
    wait_drain(200);
    n_checks++;
    if (acc_cyc[$] - acc_cyc[$-1] != 41 + TMO)
      $display("FAIL timeout_gap got %0d want %0d", acc_cyc[$] - acc_cyc[$-1], 41 + TMO);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int unsigned gap_err = 0;
    int unsigned base;
    do_reset();
    base = acc_cyc.size();
    for (int unsigned rep = 0; rep < 2; rep++)
      for (int unsigned r = 0; r < N; r++) send(r, 8'h0A);
    wait_drain(500);
    for (int unsigned i = base + 1; i < acc_cyc.size(); i++)
      if (acc_cyc[i] - acc_cyc[i-1] != 41) gap_err++;
    n_checks++;
    if (gap_err != 0 || acc_cyc.size() != base + 8)
      $display("FAIL fair_period got %0d bad gaps of %0d accepts want 0 of 8", gap_err, acc_cyc.size() - base);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int unsigned a0, a1;
    int unsigned idle_err = 0;
    do_reset();
    a0 = acc_count;
    send(0, 8'hC3);
    wait_acc(a0, 10);
    repeat (18) @(negedge clk);
    #1;
    n_checks++; if (tx !== 1'b0) $display("FAIL pre_abort_tx got %b want 0", tx); else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1) $display("FAIL abort_tx got %b want 1", tx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    a1 = acc_count;
    repeat (60) begin
      @(negedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0) idle_err++;
    end
    n_checks++; if (idle_err != 0) $display("FAIL post_abort_idle got %0d bad cycles want 0", idle_err); else n_pass++;
    n_checks++; if (acc_count != a1) $display("FAIL post_abort_accept got %0d want %0d", acc_count, a1); else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fork
      agent();
    join_none
    fork
      begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_single();
    test_simultaneous();
    test_lock();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (exp_acc.size() != 0 || tx_q.size() != 0)
      $display("FAIL leftover got %0d/%0d want 0/0", exp_acc.size(), tx_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
